// File: rtl/ultrasonic_pkg.sv
// Shared types, constants and the distance conversion helper for the ultrasonic scanner.
package ultrasonic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIGGER,
        WAIT_ECHO,
        COUNT,
        CALC,
        HOLDOFF
    } us_state_t;

    // Centimetres per 50 MHz clock cycle in Q8.24.
    localparam logic [31:0]  CM_PER_CYCLE_Q24 = 32'h1648;
    localparam int unsigned  FRAC_BITS        = 24;
    localparam int unsigned  SAT_W            = 16;

    // Drop the fraction bits and clamp to the all-ones value of a dist_w-bit field.
    function automatic logic [SAT_W-1:0] sat_dist(input logic [63:0] product,
                                                  input int unsigned dist_w);
        logic [63:0] shifted;
        logic [63:0] max_cm;
        shifted = product >> FRAC_BITS;
        max_cm  = (64'd1 << dist_w) - 64'd1;
        if (shifted > max_cm) begin
            return {SAT_W{1'b1}};
        end
        return shifted[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/ultrasonic_array_sync2.sv
// Two-flop synchroniser for a bus of independent asynchronous inputs.
module sync2 #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // Two register stages per bit to settle metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ultrasonic_array.sv
// Round-robin scanner for N_CH HC-SR04-style sensors: trigger, echo width, distance, proximity.
module ultrasonic_array
    import ultrasonic_pkg::*;
#(
    parameter int unsigned N_CH           = 4,
    parameter int unsigned TRIG_CYCLES    = 500,
    parameter int unsigned TIMEOUT_CYCLES = 1_900_000,
    parameter int unsigned HOLDOFF_CYCLES = 3_000_000,
    parameter int unsigned CNT_W          = 22,
    parameter int unsigned DIST_W         = 8
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          start,
    input  logic                                          auto_en,
    input  logic [DIST_W-1:0]                             threshold,
    input  logic [N_CH-1:0]                               echo,
    output logic [N_CH-1:0]                               trig,
    output logic                                          busy,
    output logic [N_CH*DIST_W-1:0]                        distance,
    output logic                                          dist_valid,
    output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0]    dist_ch,
    output logic [N_CH-1:0]                               timeout_err,
    output logic [N_CH-1:0]                               proximity,
    output logic                                          any_proximity
);

    localparam int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned PROD_W = CNT_W + 32;

    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(N_CH - 1);

    us_state_t          state;
    logic [CH_W-1:0]    ch;
    logic [CH_W-1:0]    ch_inc;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   width;
    logic               timed_out;
    logic [N_CH-1:0]    echo_sync;
    logic               echo_s;
    logic [PROD_W-1:0]  product;
    logic [DIST_W-1:0]  cm;
    logic [N_CH-1:0]    prox_next;

    sync2 #(.W(N_CH)) u_echo_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (echo),
        .q     (echo_sync)
    );

    assign echo_s  = echo_sync[ch];
    assign ch_inc  = ch + 1'b1;
    assign dist_ch = ch;

    // Width-to-centimetre conversion and the proximity vector as it would be after CALC.
    always_comb begin
        product       = PROD_W'(width) * PROD_W'(CM_PER_CYCLE_Q24);
        cm            = DIST_W'(sat_dist(64'(product), DIST_W));
        prox_next     = proximity;
        prox_next[ch] = !timed_out && (cm != '0) && (cm < threshold);
    end

    // Measurement sequencer; cnt times TRIGGER/HOLDOFF and serves as the echo timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ch            <= '0;
            cnt           <= '0;
            width         <= '0;
            timed_out     <= 1'b0;
            trig          <= '0;
            busy          <= 1'b0;
            distance      <= '0;
            dist_valid    <= 1'b0;
            timeout_err   <= '0;
            proximity     <= '0;
            any_proximity <= 1'b0;
        end else begin
            dist_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start || auto_en) begin
                        ch    <= '0;
                        cnt   <= '0;
                        trig  <= N_CH'(1);
                        busy  <= 1'b1;
                        state <= TRIGGER;
                    end
                end
                TRIGGER: begin
                    if (cnt == TRIG_LAST) begin
                        trig  <= '0;
                        cnt   <= '0;
                        state <= WAIT_ECHO;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_ECHO: begin
                    if (echo_s) begin
                        // The detecting cycle is already part of the pulse.
                        width <= CNT_W'(1);
                        cnt   <= cnt + 1'b1;
                        state <= COUNT;
                    end else if (cnt >= TMO_LAST) begin
                        timed_out <= 1'b1;
                        state     <= CALC;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                COUNT: begin
                    if (!echo_s) begin
                        timed_out <= 1'b0;
                        state     <= CALC;
                    end else if (cnt >= TMO_LAST) begin
                        timed_out <= 1'b1;
                        state     <= CALC;
                    end else begin
                        width <= width + 1'b1;
                        cnt   <= cnt + 1'b1;
                    end
                end
                CALC: begin
                    distance[ch*DIST_W +: DIST_W] <= timed_out ? '1 : cm;
                    timeout_err[ch] <= timed_out;
                    proximity       <= prox_next;
                    any_proximity   <= |prox_next;
                    dist_valid      <= 1'b1;
                    cnt             <= '0;
                    state           <= HOLDOFF;
                end
                HOLDOFF: begin
                    if (cnt == HOLD_LAST) begin
                        cnt <= '0;
                        if (ch != LAST_CH) begin
                            ch    <= ch_inc;
                            trig  <= N_CH'(1) << ch_inc;
                            state <= TRIGGER;
                        end else if (auto_en) begin
                            ch    <= '0;
                            trig  <= N_CH'(1);
                            state <= TRIGGER;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ultrasonic_array.sv
// Directed bench for ultrasonic_array with a behavioural sensor model driving echo.
module tb_ultrasonic_array;

    localparam int unsigned N_CH           = 4;
    localparam int unsigned TRIG_CYCLES    = 5;
    localparam int unsigned TIMEOUT_CYCLES = 12_500;
    localparam int unsigned HOLDOFF_CYCLES = 20;
    localparam int unsigned CNT_W          = 16;
    localparam int unsigned DIST_W         = 2;

    logic                     clk;
    logic                     rst_n;
    logic                     start;
    logic                     auto_en;
    logic [DIST_W-1:0]        threshold;
    logic [N_CH-1:0]          echo;
    logic [N_CH-1:0]          trig;
    logic                     busy;
    logic [N_CH*DIST_W-1:0]   distance;
    logic                     dist_valid;
    logic [1:0]               dist_ch;
    logic [N_CH-1:0]          timeout_err;
    logic [N_CH-1:0]          proximity;
    logic                     any_proximity;

    int checks = 0;
    int errors = 0;

    int echo_w [N_CH];
    int echo_dly = 10;

    ultrasonic_array #(
        .N_CH           (N_CH),
        .TRIG_CYCLES    (TRIG_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .HOLDOFF_CYCLES (HOLDOFF_CYCLES),
        .CNT_W          (CNT_W),
        .DIST_W         (DIST_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .auto_en       (auto_en),
        .threshold     (threshold),
        .echo          (echo),
        .trig          (trig),
        .busy          (busy),
        .distance      (distance),
        .dist_valid    (dist_valid),
        .dist_ch       (dist_ch),
        .timeout_err   (timeout_err),
        .proximity     (proximity),
        .any_proximity (any_proximity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sensor model: after a trigger ends, wait echo_dly cycles then echo for echo_w cycles (0 = silent).
    initial begin : responder
        int cur;
        bit armed;
        echo  = '0;
        armed = 1'b0;
        cur   = 0;
        forever begin
            @(negedge clk);
            if (trig != '0) begin
                armed = 1'b1;
                for (int k = 0; k < N_CH; k++) begin
                    if (trig[k]) cur = k;
                end
            end else if (armed) begin
                armed = 1'b0;
                if (echo_w[cur] > 0) begin
                    repeat (echo_dly) @(negedge clk);
                    echo[cur] = 1'b1;
                    repeat (echo_w[cur]) @(negedge clk);
                    echo[cur] = 1'b0;
                end
            end
        end
    end

    function automatic logic [DIST_W-1:0] dist_of(input int k);
        return distance[k*DIST_W +: DIST_W];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dist_valid && n < budget);
        check("dist_valid_seen", 32'(dist_valid), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < budget);
        check("busy_fall", 32'(busy), 32'd0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic quiet(input string tag, input int cycles);
        int seen;
        seen = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (dist_valid || busy) seen++;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    initial begin : stimulus
        int n;
        int exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};
        rst_n     = 1'b0;
        start     = 1'b0;
        auto_en   = 1'b0;
        threshold = 2'd2;
        echo_w    = '{3000, 6000, 12000, 0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_trig", 32'(trig), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_distance", 32'(distance), 32'd0);
        check("rst_outputs", 32'({dist_valid, dist_ch, timeout_err, proximity, any_proximity}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single sweep, threshold 2: 3000 -> 1 cm, 6000 -> 2 cm, 12000 -> saturated 3, ch3 times out
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_trig", 32'(trig), 32'b0001);
        n = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!trig[0]) break;
            n++;
        end
        check("trig0_width", 32'(n), 32'd5);

        wait_valid(5000);
        check("s1_ch0_dist_ch", 32'(dist_ch), 32'd0);
        check("s1_ch0_dist", 32'(dist_of(0)), 32'd1);
        check("s1_ch0_prox", 32'(proximity[0]), 32'd1);
        check("s1_ch0_terr", 32'(timeout_err[0]), 32'd0);
        check("s1_any_prox", 32'(any_proximity), 32'd1);
        @(negedge clk);
        check("valid_one_cycle", 32'(dist_valid), 32'd0);
        pulse_start();

        wait_valid(8000);
        check("s1_ch1_dist_ch", 32'(dist_ch), 32'd1);
        check("s1_ch1_dist", 32'(dist_of(1)), 32'd2);
        check("s1_ch1_prox", 32'(proximity[1]), 32'd0);

        wait_valid(14000);
        check("s1_ch2_dist_sat", 32'(dist_of(2)), 32'd3);
        check("s1_ch2_terr", 32'(timeout_err[2]), 32'd0);

        wait_valid(14000);
        check("s1_ch3_dist_ch", 32'(dist_ch), 32'd3);
        check("s1_ch3_dist", 32'(dist_of(3)), 32'd3);
        check("s1_terr_vec", 32'(timeout_err), 32'b1000);
        check("s1_prox_vec", 32'(proximity), 32'b0001);
        wait_idle(100);
        quiet("s1_no_extra_sweep", 50);

        // Threshold 3 does not touch stored flags; second sweep exercises 0 cm and exact max
        threshold = 2'd3;
        repeat (2) @(negedge clk);
        check("thr_no_reeval", 32'(proximity), 32'b0001);
        echo_w = '{1000, 6000, 8900, 3000};
        pulse_start();
        wait_valid(5000);
        check("s2_ch0_dist_zero", 32'(dist_of(0)), 32'd0);
        check("s2_ch0_prox_zero", 32'(proximity[0]), 32'd0);
        wait_valid(8000);
        check("s2_ch1_prox", 32'(proximity[1]), 32'd1);
        wait_valid(12000);
        check("s2_ch2_dist", 32'(dist_of(2)), 32'd3);
        check("s2_ch2_prox", 32'(proximity[2]), 32'd0);
        wait_valid(5000);
        check("s2_ch3_dist", 32'(dist_of(3)), 32'd1);
        check("s2_terr_clear", 32'(timeout_err), 32'd0);
        check("s2_prox_vec", 32'(proximity), 32'b1010);
        wait_idle(100);

        // Auto mode order, then drop auto_en during ch1 of the second sweep
        echo_w  = '{1000, 1000, 1000, 1000};
        @(negedge clk);
        auto_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_valid(3000);
            check("auto_order", 32'(dist_ch), 32'(exp_order[i]));
        end
        n = 0;
        while (!trig[1] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("auto_trig1_seen", 32'(trig[1]), 32'd1);
        auto_en = 1'b0;
        pulse_start();
        for (int i = 1; i < 4; i++) begin
            wait_valid(3000);
            check("auto_drain_order", 32'(dist_ch), 32'(i));
        end
        wait_idle(100);
        quiet("auto_stop", 300);
        check("auto_prox_vec", 32'({any_proximity, proximity}), 32'd0);

        // Reset during ch1 COUNT
        echo_w = '{6000, 3000, 1000, 1000};
        pulse_start();
        wait_valid(8000);
        check("rstm_ch0_dist", 32'(dist_of(0)), 32'd2);
        check("rstm_ch0_any", 32'(any_proximity), 32'd1);
        n = 0;
        while (!echo[1] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rstm_echo1_seen", 32'(echo[1]), 32'd1);
        repeat (100) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rstm_trig", 32'(trig), 32'd0);
        check("rstm_busy", 32'(busy), 32'd0);
        check("rstm_distance", 32'(distance), 32'd0);
        check("rstm_outputs", 32'({dist_valid, dist_ch, timeout_err, proximity, any_proximity}), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        quiet("rstm_no_result", 4000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
